// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and transmitter state encoding
package uart_pkg;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 10416;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO with first-word-fall-through output
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [UART_DATA_BITS-1:0] din,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      full,
    output logic                      empty,
    output logic [AW:0]               count
);
    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] count_q, count_d;
    logic full_q, full_d;
    logic do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop = pop && count_q != '0;

    always_comb begin
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d = count_d == (AW+1)'(DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
            full_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

    assign dout = mem[rd_q];
    assign full = full_q;
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first UART transmitter fed from an internal byte FIFO
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    tx_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d, dout;
    logic [2:0] idx_q, idx_d;
    logic tx_q, tx_d, active_q, active_d;
    logic full, empty, pop, bit_end;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(data_valid && !full), .pop(pop),
        .din(data_in), .dout(dout), .full(full), .empty(empty), .count(fifo_count)
    );

    always_comb begin
        bit_end = baud_q == BAUD_MAX;
        baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
        state_d = state_q;
        shift_d = shift_q;
        idx_d = idx_q;
        pop = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop = 1'b1;
                shift_d = dout;
                state_d = START;
            end
            START: if (bit_end) begin
                state_d = DATA;
                idx_d = '0;
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                idx_d = idx_q + 1'b1;
                state_d = idx_q == 3'(UART_DATA_BITS - 1) ? STOP : DATA;
            end
            default: if (bit_end) begin
                pop = !empty;
                shift_d = empty ? shift_q : dout;
                state_d = empty ? IDLE : START;
            end
        endcase
        // tx is registered from the current state, so the line lags the FSM by one cycle
        tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
        active_d = state_q != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q <= '0;
            shift_q <= '0;
            idx_q <= '0;
            tx_q <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            shift_q <= shift_d;
            idx_q <= idx_d;
            tx_q <= tx_d;
            active_q <= active_d;
        end
    end

    assign tx = tx_q;
    assign ready = !full;
    // active_q covers the final stop-bit cycle still on the line after the FSM returns to IDLE
    assign busy = state_q != IDLE || !empty || active_q;
endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-oriented UART transmitter, 8N1, LSB first, with an internal FIFO so a producer (e.g. the hash/cipher result serializer) can push a burst of bytes without waiting on the line. It is the transmit-side counterpart of the existing UART receive path. Both share one 100 MHz clock and the same cycles-per-bit constant, so a loopback of `tx` into the receiver reproduces the byte stream.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 10416: clock cycles per UART bit (9600 baud at 100 MHz); legal range 4..16383.
- `FIFO_DEPTH`, default 16: byte entries; must be a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high; clears all state.
- `data_in`  in  8  byte to transmit.
- `data_valid`  in  1  write strobe; byte is accepted on a rising edge where `data_valid && ready`.
- `ready`  out  1  FIFO not full (registered).
- `tx`  out  1  serial line, idle high (registered, glitch-free).
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.

## Operation

- **Reset values:** `tx`=1, `ready`=1, `busy`=0, `fifo_count`=0. The FSM is in IDLE, FIFO pointers are 0 and the bit counter is 0.
- **Frame format:** start(0), d[0]..d[7], stop(1). That is 10 bits, each held for exactly `CLKS_PER_BIT` cycles.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and go to START.
  - START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]` and shift right at the end of each bit. After bit index 7 completes, go to STOP.
  - STOP: drive 1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1, with a bit-end pulse at `CLKS_PER_BIT`-1. Width is $clog2(CLKS_PER_BIT). The count is never preloaded with half a bit.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. `fifo_count` changes by +1 on a push only, -1 on a pop only, and is unchanged when both happen.
- **Full:** `data_valid` with `ready`=0 is ignored. No overwrite and no error flag.
- **Push and pop on the same edge:**
  - FIFO full: the pop frees a slot, but `ready` was 0, so the push is not accepted that cycle.
  - FIFO empty: the push is accepted; there is no pop that edge.
- **Reset mid-frame:** `tx` returns to 1 asynchronously, and the queued bytes and the partial frame are discarded.
- `data_in` changes while `ready`=0 have no effect.

## Timing

- Accept a byte on edge k into an empty FIFO with an idle FSM:
  - pop on edge k+1;
  - `tx` falls after edge k+2;
  - latency is 2 cycles.
- Frame duration is 10×`CLKS_PER_BIT` cycles. With a non-empty FIFO, back-to-back frames abut exactly.
- `ready` deasserts the cycle after the push that fills the FIFO, and reasserts the cycle after the next pop.
- `busy` rises the cycle after the first accepted push. It falls the cycle after the STOP bit of the last queued byte ends.

## Structure

- Shared package `uart_pkg` holds:
  - `UART_CLKS_PER_BIT_DEFAULT` = 10416;
  - `UART_DATA_BITS` = 8;
  - the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
- One sub-module, `uart_tx_fifo`: a synchronous single-clock FIFO with parameter `DEPTH`, ports `push`/`pop`/`din`/`dout`/`full`/`empty`/`count`, and first-word-fall-through output.
- The FSM, baud counter and shift register stay in `uart_tx`.

## Test plan

- **Reset idle:** reset, then idle for 50k cycles → `tx`=1 throughout, `ready`=1, `busy`=0, `fifo_count`=0.
- **Single byte:** `CLKS_PER_BIT`=16, push 0xA5 → `tx` bits 0,1,0,1,0,0,1,0,1,1, each exactly 16 cycles. Start edge 2 cycles after the accept. `busy` falls after 160 cycles of frame.
- **Full FIFO:** `CLKS_PER_BIT`=16, DEPTH=4, push 0x00..0x05 on consecutive cycles. Expected: 0x00 popped to the shifter, 0x01..0x04 queued, 0x05 rejected (`ready`=0). Line shows 0x00..0x04 back-to-back with no idle bits between stop and start.
- **Push on the pop edge:** with FIFO full, hold `data_valid` through the STOP→START pop edge. The byte is not accepted on that edge; it is accepted on the next edge once `ready`=1, and `fifo_count` returns to DEPTH.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 3 bytes queued. `tx`=1 immediately and `fifo_count`=0. After release, a new byte 0x3C is sent correctly.
- **Loopback:** with default `CLKS_PER_BIT`, connect `tx` to the UART receiver and send 0x00, 0xFF, 0x55, 0x80 → the receiver outputs the identical sequence.
